// File: rtl/mem_access_ctrl_if.sv
// Request/response and RAM pin bundle for mem_access_ctrl.
// The controller takes the slave view; the requester plus RAM side takes the master view.
`timescale 1ns/1ps
interface mem_access_ctrl_if #(
  parameter int WORD_SIZE    = 16,
  parameter int ADDRESS_SIZE = 16
);
  logic                    req_valid;
  logic                    req_ready;
  logic [1:0]              req_op;
  logic [ADDRESS_SIZE-1:0] req_addr;
  logic [WORD_SIZE-1:0]    req_wdata;
  logic                    rsp_valid;
  logic [WORD_SIZE-1:0]    rsp_rdata;
  logic                    ram_read;
  logic                    ram_write;
  logic [ADDRESS_SIZE-1:0] ram_address;
  logic [WORD_SIZE-1:0]    ram_in_data;
  logic [WORD_SIZE-1:0]    ram_out_data;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, ram_out_data,
    input  req_ready, rsp_valid, rsp_rdata, ram_read, ram_write, ram_address, ram_in_data
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, ram_out_data,
    output req_ready, rsp_valid, rsp_rdata, ram_read, ram_write, ram_address, ram_in_data
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// LC-3 memory sequencer: one request at a time, absorbs RAM read latency, does LDI/STI pointer fetch.
// Optional LC3_MMIO_EN maps DSR (0xFE04) reads and DDR (0xFE06) writes to the ddr_* outputs.
`timescale 1ns/1ps
module mem_access_ctrl #(
  parameter int WORD_SIZE    = 16,
  parameter int ADDRESS_SIZE = 16
) (
  input  logic               clock,
  input  logic               reset,
  mem_access_ctrl_if.slave   bus
`ifdef LC3_MMIO_EN
  ,
  output logic               ddr_valid,
  output logic [WORD_SIZE-1:0] ddr_data
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PTR   = 3'd1,
    S_PTR_W = 3'd2,
    S_RD    = 3'd3,
    S_RD_W  = 3'd4,
    S_WR    = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t                  state_q, state_d;
  logic                    is_wr_q;
  logic [ADDRESS_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0]    wdata_q;
  logic [WORD_SIZE-1:0]    rdata_q;
  logic                    rd_strobe, wr_strobe;
  logic                    dsr_hit, ddr_hit;

`ifdef LC3_MMIO_EN
  localparam logic [ADDRESS_SIZE-1:0] DSR_ADDR = ADDRESS_SIZE'(16'hFE04);
  localparam logic [ADDRESS_SIZE-1:0] DDR_ADDR = ADDRESS_SIZE'(16'hFE06);
  localparam logic [WORD_SIZE-1:0]    DSR_READY = WORD_SIZE'(16'h8000);

  assign dsr_hit = (addr_q == DSR_ADDR);
  assign ddr_hit = (addr_q == DDR_ADDR);

  // Display is always ready; a DDR write lands in ddr_data and pulses with DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      ddr_valid <= 1'b0;
      ddr_data  <= '0;
    end else begin
      ddr_valid <= (state_q == S_WR) && ddr_hit;
      if ((state_q == S_WR) && ddr_hit)
        ddr_data <= wdata_q;
    end
  end
`else
  assign dsr_hit = 1'b0;
  assign ddr_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            is_wr_q <= bus.req_op[0];
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
          end
        end
        // Pointer word arrives one cycle after the PTR read strobe.
        S_PTR_W: addr_q <= bus.ram_out_data[ADDRESS_SIZE-1:0];
        S_RD_W: begin
`ifdef LC3_MMIO_EN
          rdata_q <= dsr_hit ? DSR_READY : bus.ram_out_data;
`else
          rdata_q <= bus.ram_out_data;
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    rd_strobe     = 1'b0;
    wr_strobe     = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          case (bus.req_op)
            2'b00:   state_d = S_RD;
            2'b01:   state_d = S_WR;
            default: state_d = S_PTR;
          endcase
        end
      end
      S_PTR: begin
        rd_strobe = 1'b1;
        state_d   = S_PTR_W;
      end
      S_PTR_W: state_d = is_wr_q ? S_WR : S_RD;
      S_RD: begin
        rd_strobe = !dsr_hit;
        state_d   = S_RD_W;
      end
      S_RD_W: state_d = S_DONE;
      S_WR: begin
        wr_strobe = !ddr_hit;
        state_d   = S_DONE;
      end
      S_DONE: begin
        bus.rsp_valid = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are suppressed in any reset cycle, including an abort mid-operation.
  assign bus.ram_read    = rd_strobe && !reset;
  assign bus.ram_write   = wr_strobe && !reset;
  assign bus.ram_address = addr_q;
  assign bus.ram_in_data = wdata_q;
  assign bus.rsp_rdata   = rdata_q;

endmodule
